// File: rtl/r_file.sv
// r_file: 32 x 32-bit register file with MIPS R/I-format field decode.
// Source operands are read combinationally from the rs/rt fields of the
// current instruction word. Write-back comes in on a separate port.
module r_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instru,
    input  logic [4:0]  Rw,
    input  logic [31:0] Di,
    input  logic        WE,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] imm16,
    output logic [31:0] busA,
    output logic [31:0] busB
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned NUM_REGS = 32;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [IDX_W-1:0]  rs_idx_c;
    logic [IDX_W-1:0]  rt_idx_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [IMM_W-1:0]  imm_c;
    logic              wr_en_c;

    // The opcode and funct fields are decoded elsewhere in the datapath.
    logic              unused_opcode;
    assign unused_opcode = ^instru[31:26];

    // Instruction field extraction.
    always_comb begin
        rs_idx_c = instru[25:21];
        rt_idx_c = instru[20:16];
        rd_idx_c = instru[15:11];
        imm_c    = instru[15:0];
    end

    // Writes to register 0 are dropped so it always reads back zero.
    always_comb begin
        wr_en_c = 1'b0;
        if (WE && (Rw != IDX_W'(0))) begin
            wr_en_c = 1'b1;
        end
    end

    // Register array: async clear, single write port on the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs[Rw] <= Di;
        end
    end

    // Combinational reads, no write bypass; index 0 forced to zero.
    always_comb begin
        busA = '0;
        busB = '0;
        if (rs_idx_c != IDX_W'(0)) begin
            busA = regs[rs_idx_c];
        end
        if (rt_idx_c != IDX_W'(0)) begin
            busB = regs[rt_idx_c];
        end
    end

    // Decode outputs are plain slices of the instruction word.
    always_comb begin
        Rt    = rt_idx_c;
        Rd    = rd_idx_c;
        imm16 = imm_c;
    end

endmodule

// File: tb/tb_r_file.sv
// Directed self-checking bench for r_file.
module tb_r_file;

    logic        clk;
    logic        reset;
    logic [31:0] instru;
    logic [4:0]  Rw;
    logic [31:0] Di;
    logic        WE;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] imm16;
    logic [31:0] busA;
    logic [31:0] busB;

    int tests;
    int failed;

    r_file dut (
        .clk    (clk),
        .reset  (reset),
        .instru (instru),
        .Rw     (Rw),
        .Di     (Di),
        .WE     (WE),
        .Rt     (Rt),
        .Rd     (Rd),
        .imm16  (imm16),
        .busA   (busA),
        .busB   (busB)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Present a write for exactly one rising edge, launched from a falling edge.
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        Rw = idx;
        Di = data;
        WE = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
        return {6'b0, rs, rt, rd, 5'd0, 6'b100000};
    endfunction

    logic [31:0] exp_val;

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        instru = 32'h0;
        Rw     = 5'd0;
        Di     = 32'h0;
        WE     = 1'b0;

        // Reset state
        #12;
        chk("rst_busA", busA, 32'h0);
        chk("rst_busB", busB, 32'h0);
        instru = 32'hA5A5_C3C3;
        #1;
        chk("rst_Rt", 32'(Rt), 32'h05);
        chk("rst_Rd", 32'(Rd), 32'h18);
        chk("rst_imm16", 32'(imm16), 32'h0000_C3C3);
        @(negedge clk);
        reset  = 1'b0;
        instru = 32'h0;

        // Reset clear: reg3 written, then async reset mid-cycle
        write_reg(5'd3, 32'hDEAD_BEEF);
        instru = mk_r(5'd3, 5'd3, 5'd0);
        #1;
        chk("pre_rst_busA", busA, 32'hDEAD_BEEF);
        chk("pre_rst_busB", busB, 32'hDEAD_BEEF);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_busA", busA, 32'h0);
        chk("async_rst_busB", busB, 32'h0);
        // Write attempted while reset held across an edge must be ignored
        WE = 1'b1;
        Rw = 5'd3;
        Di = 32'h1111_2222;
        @(negedge clk);
        WE    = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_reg3", busA, 32'h0);

        // Basic write/read
        instru = mk_r(5'd1, 5'd2, 5'd3);
        write_reg(5'd2, 32'd5);
        #1;
        chk("basic_busB", busB, 32'd5);
        chk("basic_busA", busA, 32'h0);
        chk("basic_Rt", 32'(Rt), 32'd2);
        chk("basic_Rd", 32'(Rd), 32'd3);
        chk("basic_imm16", 32'(imm16), 32'h0000_1820);

        // Write disable
        Rw = 5'd1;
        Di = 32'h0;
        WE = 1'b0;
        @(negedge clk);
        Rw = 5'd2;
        Di = 32'h0000_0077;
        @(negedge clk);
        chk("we0_busB", busB, 32'd5);
        chk("we0_busA", busA, 32'h0);

        // Register zero
        write_reg(5'd0, 32'hFFFF_FFFF);
        instru = mk_r(5'd0, 5'd0, 5'd0);
        #1;
        chk("r0_busA", busA, 32'h0);
        chk("r0_busB", busB, 32'h0);

        // Read-during-write on the same index
        instru = mk_r(5'd7, 5'd7, 5'd0);
        @(negedge clk);
        Rw = 5'd7;
        Di = 32'h1234_5678;
        WE = 1'b1;
        #1;
        chk("rdw_before_busA", busA, 32'h0);
        chk("rdw_before_busB", busB, 32'h0);
        @(posedge clk);
        #1;
        chk("rdw_after_busA", busA, 32'h1234_5678);
        chk("rdw_after_busB", busB, 32'h1234_5678);
        @(negedge clk);
        WE = 1'b0;

        // Full sweep
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 32; i++) begin
            instru = mk_r(5'(i), 5'(31 - i), 5'd0);
            #1;
            exp_val = (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101;
            chk($sformatf("sweep_busA_%0d", i), busA, exp_val);
            exp_val = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h0101_0101;
            chk($sformatf("sweep_busB_%0d", 31 - i), busB, exp_val);
        end

        // Async reset clears the whole array
        instru = mk_r(5'd31, 5'd16, 5'd0);
        #1;
        chk("pre_final_rst_busA", busA, 32'h1F1F_1F1F);
        reset = 1'b1;
        #1;
        chk("final_rst_busA", busA, 32'h0);
        chk("final_rst_busB", busB, 32'h0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/r_file.md
Name: r_file

Overview:
- 32 x 32-bit general-purpose register file with integrated MIPS R-/I-format field decode.
- Takes the current 32-bit instruction word, extracts the register specifiers and the 16-bit immediate, and drives the two source operands combinationally.
- Sits between instruction fetch/decode and the ALU in the single-cycle CPU datapath.
- Write-back arrives on a separate port (Rw/Di/WE).

Parameters:
- None. All widths are fixed: 32 registers, 32-bit data, 5-bit specifiers.

Ports:
- clk    input   1   system clock; writes occur on the rising edge
- reset  input   1   asynchronous, active-high; clears all registers
- instru input   32  current instruction word
- Rw     input   5   write-back destination register index
- Di     input   32  write-back data
- WE     input   1   write enable, active-high
- Rt     output  5   instru[20:16]
- Rd     output  5   instru[15:11]
- imm16  output  16  instru[15:0]
- busA   output  32  contents of register instru[25:21] (rs)
- busB   output  32  contents of register instru[20:16] (rt)

Behaviour:
- Storage: 32 entries x 32 bits, indexed 0..31.
- Register 0 is hardwired to zero.
  - Reads of index 0 always return 32'h0.
  - Writes to index 0 are discarded.
- Reset (async, active-high):
  - While reset=1, all 32 registers are 0, independent of clk.
  - A write in the same cycle as reset is ignored.
  - Deassertion takes effect at the next rising clk edge.
- Write:
  - On the rising edge of clk with reset=0, WE=1 and Rw!=0, reg[Rw] <= Di.
  - With WE=0, no register changes.
  - Single write port only.
- Read:
  - Purely combinational, zero latency.
  - busA = reg[instru[25:21]], busB = reg[instru[20:16]].
  - Outputs update immediately when instru changes or a register is updated.
- Read-during-write, same index:
  - No bypass.
  - Before the edge the bus shows the old value.
  - After the edge it shows Di.
- Decode outputs:
  - Rt, Rd and imm16 are pure combinational slices of instru.
  - They are independent of reset and clk.
- Reset values of outputs:
  - busA = busB = 0.
  - Rt, Rd, imm16 follow instru.
- Undefined/X-free:
  - After reset, no output may be X for any defined instru.

Test Plan:
- Reset clear: write reg3=32'hDEADBEEF, then pulse reset=1 mid-cycle (no clk edge) -> busA/busB read 0 immediately for rs=rt=3; register still 0 after reset released.
- Basic write/read:
  - instru={6'b0,5'd1,5'd2,5'd3,5'd0,6'b100000}, WE=1, Rw=2, Di=5.
  - After first posedge -> busB=5, busA=0.
  - Rt=2, Rd=3, imm16=16'h1820.
- Write disable: WE=0, Rw=1, Di=0 after the above -> reg2 stays 5 (busB=5), reg1 unchanged (busA=0).
- Register zero: WE=1, Rw=0, Di=32'hFFFFFFFF, posedge, instru rs=0 -> busA=0.
- Read-during-write timing:
  - rs=rt=7, WE=1, Rw=7, Di=32'h12345678.
  - busA shows old value 0 before the edge and 32'h12345678 after it.
- Full sweep:
  - Write reg[i]=i*32'h01010101 for i=1..31.
  - Read back all via rs and rt -> exact match; reg0=0.
